data_mem_responder: RTL and testbench

- Multi-cycle, stall-generating data-memory responder on the far side of the MEM-stage load/store interface.
- The pipeline's MEM stage issues requests: read, write, byte store or double (64-bit FP) transfer. This block serves each one from an internal word array with configurable latency.
- While a request is in flight it holds the pipeline with `stall`.
- It returns read data, and an error flag for illegal accesses, with a one-cycle `resp_valid` pulse.

---
 rtl/data_mem_responder.sv | 189 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data-memory responder for the MEM-stage
// load/store interface. Each request is served from an internal word array
// with a configurable per-word latency. The pipeline is held with a stall
// while a request is in flight, and one resp_valid pulse marks completion.
module data_mem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_read,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_double,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_wdata_hi,
  output logic              req_ready,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [31:0]       resp_rdata_hi,
  output logic              err_misaligned
);

  localparam int         IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_RELOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1,
    DONE
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [3:0]        cnt;

  logic              cap_read;
  logic              cap_write;
  logic              cap_byte;
  logic              cap_double;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0]       cap_wdata;
  logic [31:0]       cap_wdata_hi;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              req_illegal;
  logic              accept;
  logic              commit;
  logic              byte_store;
  logic [IDX_W-1:0]  idx0;
  logic [IDX_W-1:0]  idx1;
  logic [4:0]        lane_shift;
  logic [31:0]       lane_mask;
  logic [31:0]       byte_merged;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [31:0]       wr_data;

  // Legality is judged on the live request, so an illegal request can go
  // straight to DONE on its acceptance edge. A byte flag on a read is just a
  // word read and still needs word alignment.
  assign req_illegal = (req_read && req_write)
                    || (req_double && (req_addr[2:0] != 3'b000))
                    || (!req_double && !(req_byte && req_write) && (req_addr[1:0] != 2'b00));

  // Word indices wrap modulo the array depth; the second word of a double
  // wraps to index 0 at the top of the array.
  assign idx0 = IDX_W'(cap_addr[ADDR_W-1:2]);
  assign idx1 = idx0 + IDX_W'(1);

  // Byte stores are big-endian: byte offset 0 is the most significant lane.
  assign byte_store  = cap_byte && cap_write && !cap_double;
  assign lane_shift  = {~cap_addr[1:0], 3'b000};
  assign lane_mask   = 32'h0000_00FF << lane_shift;
  assign byte_merged = (mem[idx0] & ~lane_mask) | ({24'h0, cap_wdata[7:0]} << lane_shift);

  assign wr_en   = commit && cap_write;
  assign wr_idx  = (state == ACC1) ? idx1 : idx0;
  assign wr_data = (state == ACC1) ? cap_wdata_hi : (byte_store ? byte_merged : cap_wdata);

  // State register; reset aborts any access in flight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the handshake outputs (ready, stall, valid).
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    commit     = 1'b0;
    req_ready  = 1'b0;
    stall      = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && (req_read || req_write)) begin
          accept     = 1'b1;
          stall      = 1'b1;
          next_state = req_illegal ? DONE : ACC0;
        end
      end
      ACC0: begin
        stall = 1'b1;
        if (cnt == 4'd0) begin
          commit     = 1'b1;
          next_state = cap_double ? ACC1 : DONE;
        end
      end
      ACC1: begin
        stall = 1'b1;
        if (cnt == 4'd0) begin
          commit     = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request capture, latency counter and registered response data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= 4'd0;
      cap_read       <= 1'b0;
      cap_write      <= 1'b0;
      cap_byte       <= 1'b0;
      cap_double     <= 1'b0;
      cap_addr       <= '0;
      cap_wdata      <= 32'h0;
      cap_wdata_hi   <= 32'h0;
      resp_rdata     <= 32'h0;
      resp_rdata_hi  <= 32'h0;
      err_misaligned <= 1'b0;
    end else if (accept) begin
      cnt          <= CNT_RELOAD;
      cap_read     <= req_read;
      cap_write    <= req_write;
      cap_byte     <= req_byte;
      cap_double   <= req_double;
      cap_addr     <= req_addr;
      cap_wdata    <= req_wdata;
      cap_wdata_hi <= req_wdata_hi;
      if (req_illegal) begin
        err_misaligned <= 1'b1;
        resp_rdata     <= 32'h0;
        resp_rdata_hi  <= 32'h0;
      end
    end else if ((state == ACC0) || (state == ACC1)) begin
      if (cnt == 4'd0) begin
        cnt <= CNT_RELOAD;
        if (cap_read) begin
          if (state == ACC0) begin
            resp_rdata <= mem[idx0];
          end else begin
            resp_rdata_hi <= mem[idx1];
          end
        end
        if (next_state == DONE) begin
          err_misaligned <= 1'b0;
        end
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Word array; deliberately not reset so contents survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed and randomized checks of data_mem_responder
// against a word-array reference model built from the access rules.
module tb_data_mem_responder;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 256;
  localparam int LAT    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic        req_byte = 1'b0;
  logic        req_double = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] req_wdata_hi = 32'h0;
  logic        req_ready;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [31:0] resp_rdata_hi;
  logic        err_misaligned;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_model [DEPTH];
  logic [31:0] exp_rdata = 32'h0;
  logic [31:0] exp_hi    = 32'h0;
  logic        exp_err   = 1'b0;

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  data_mem_responder #(
    .ADDR_W(ADDR_W),
    .DEPTH_WORDS(DEPTH),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_read(req_read),
    .req_write(req_write),
    .req_byte(req_byte),
    .req_double(req_double),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_wdata_hi(req_wdata_hi),
    .req_ready(req_ready),
    .stall(stall),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_rdata_hi(resp_rdata_hi),
    .err_misaligned(err_misaligned)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit is_illegal(input bit r, input bit w, input bit b, input bit d,
                                    input logic [31:0] addr);
    if (r && w) return 1'b1;
    if (d) return (addr % 8) != 0;
    if (b && w) return 1'b0;
    return (addr % 4) != 0;
  endfunction

  // Issues one request, follows it to resp_valid, updates the model and
  // compares timing and response fields.
  task automatic apply_stimulus(input string tag, input bit r, input bit w, input bit b,
                                input bit d, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] wdh);
    int  stalls;
    int  cycles;
    int  exp_stalls;
    int  idx;
    int  idx_hi;
    int  sh;
    bit  got;
    bit  bad;
    @(posedge clk); #1;
    req_valid    = 1'b1;
    req_read     = r;
    req_write    = w;
    req_byte     = b;
    req_double   = d;
    req_addr     = addr;
    req_wdata    = wd;
    req_wdata_hi = wdh;
    stalls = 0;
    cycles = 0;
    got    = 1'b0;
    while (!got && cycles < 64) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
      end else begin
        if (stall) stalls++;
        @(posedge clk); #1;
        if (cycles == 0) begin
          req_valid    = 1'b0;
          req_read     = 1'($urandom);
          req_write    = 1'($urandom);
          req_byte     = 1'($urandom);
          req_double   = 1'($urandom);
          req_addr     = $urandom;
          req_wdata    = $urandom;
          req_wdata_hi = $urandom;
        end
      end
      cycles++;
    end

    bad    = is_illegal(r, w, b, d, addr);
    idx    = int'((addr >> 2) % DEPTH);
    idx_hi = (idx + 1) % DEPTH;
    if (bad) begin
      exp_err    = 1'b1;
      exp_rdata  = 32'h0;
      exp_hi     = 32'h0;
      exp_stalls = 1;
    end else begin
      exp_err    = 1'b0;
      exp_stalls = d ? (2 * LAT + 1) : (LAT + 1);
      if (w) begin
        if (d) begin
          mem_model[idx]    = wd;
          mem_model[idx_hi] = wdh;
        end else if (b) begin
          sh = 8 * (3 - int'(addr % 4));
          mem_model[idx] = (mem_model[idx] & ~(32'hFF << sh)) | ({24'h0, wd[7:0]} << sh);
        end else begin
          mem_model[idx] = wd;
        end
      end else begin
        exp_rdata = mem_model[idx];
        if (d) exp_hi = mem_model[idx_hi];
      end
    end

    check_output({tag, "/resp_valid"}, 32'(got), 32'd1);
    check_output({tag, "/stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    check_output({tag, "/stall_in_done"}, 32'(stall), 32'd0);
    check_output({tag, "/err"}, 32'(err_misaligned), 32'(exp_err));
    check_output({tag, "/rdata"}, resp_rdata, exp_rdata);
    check_output({tag, "/rdata_hi"}, resp_rdata_hi, exp_hi);
    @(negedge clk);
    check_output({tag, "/pulse_len"}, 32'(resp_valid), 32'd0);
    check_output({tag, "/ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int          k;
    bit          r, w, b, d;
    logic [31:0] a;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_output("reset/req_ready", 32'(req_ready), 32'd1);
    check_output("reset/resp_valid", 32'(resp_valid), 32'd0);
    check_output("reset/stall", 32'(stall), 32'd0);
    check_output("reset/rdata", resp_rdata, 32'h0);
    check_output("reset/rdata_hi", resp_rdata_hi, 32'h0);
    check_output("reset/err", 32'(err_misaligned), 32'd0);
    rst_n = 1'b1;

    // Fill the array so every later read has a known model value
    $display("[TB] filling array");
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus("fill", 1'b0, 1'b1, 1'b0, 1'b0, 32'(i * 4), $urandom, 32'h0);
    end

    // Test 1: word write then read
    apply_stimulus("t1_write", 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0);
    apply_stimulus("t1_read", 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0);
    check_output("t1_const", resp_rdata, 32'hDEADBEEF);

    // Test 2: big-endian byte store
    apply_stimulus("t2_byte", 1'b0, 1'b1, 1'b1, 1'b0, 32'h12, 32'h0000_0055, 32'h0);
    apply_stimulus("t2_read", 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0);
    check_output("t2_const", resp_rdata, 32'hDEAD55EF);

    // Test 3: misaligned double at the top word, then aligned double
    apply_stimulus("t3_dw_bad", 1'b0, 1'b1, 1'b0, 1'b1, 32'h3FC, 32'h11111111, 32'h22222222);
    apply_stimulus("t3_dr_bad", 1'b1, 1'b0, 1'b0, 1'b1, 32'h3FC, 32'h0, 32'h0);
    apply_stimulus("t3_top_word", 1'b1, 1'b0, 1'b0, 1'b0, 32'h3FC, 32'h0, 32'h0);
    apply_stimulus("t3_dw_ok", 1'b0, 1'b1, 1'b0, 1'b1, 32'h3F8, 32'h11111111, 32'h22222222);
    apply_stimulus("t3_dr_ok", 1'b1, 1'b0, 1'b0, 1'b1, 32'h3F8, 32'h0, 32'h0);
    check_output("t3_const_lo", resp_rdata, 32'h11111111);
    check_output("t3_const_hi", resp_rdata_hi, 32'h22222222);

    // Test 4: addresses beyond the array alias modulo the depth
    apply_stimulus("t4_alias_w", 1'b0, 1'b1, 1'b0, 1'b1, 32'h408, 32'hA5A5A5A5, 32'h5A5A5A5A);
    apply_stimulus("t4_alias_r", 1'b1, 1'b0, 1'b0, 1'b0, 32'h00C, 32'h0, 32'h0);
    check_output("t4_const", resp_rdata, 32'h5A5A5A5A);

    // Test 5: misaligned word read and read+write conflict
    apply_stimulus("t5_mis_read", 1'b1, 1'b0, 1'b0, 1'b0, 32'h13, 32'h0, 32'h0);
    check_output("t5_const_rdata", resp_rdata, 32'h0);
    apply_stimulus("t5_rw", 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'hFFFFFFFF, 32'h0);
    apply_stimulus("t5_unchanged", 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0);
    check_output("t5_const_mem", resp_rdata, 32'hDEAD55EF);

    // No-op request: valid with neither read nor write
    @(posedge clk); #1;
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b0;
    @(negedge clk);
    check_output("noop/stall", 32'(stall), 32'd0);
    @(negedge clk);
    check_output("noop/ready", 32'(req_ready), 32'd1);
    check_output("noop/resp_valid", 32'(resp_valid), 32'd0);
    req_valid = 1'b0;

    // Randomized mix of legal and illegal requests
    for (int n = 0; n < 80; n++) begin
      k = int'($urandom_range(0, 5));
      a = $urandom_range(0, 32'h7FF) & ~32'h7;
      r = 1'b0; w = 1'b0; b = 1'b0; d = 1'b0;
      case (k)
        0: r = 1'b1;
        1: w = 1'b1;
        2: begin w = 1'b1; b = 1'b1; a = a + $urandom_range(0, 3); end
        3: begin r = 1'b1; d = 1'b1; end
        4: begin w = 1'b1; d = 1'b1; end
        default: begin r = 1'b1; w = 1'b1; end
      endcase
      if (!b && $urandom_range(0, 3) == 0) a = a + $urandom_range(1, 7);
      else if (!b && !d && $urandom_range(0, 1) == 0) a = a + 32'h4;
      apply_stimulus($sformatf("rand%0d", n), r, w, b, d, a, $urandom, $urandom);
    end

    // Test 6: reset during the second word of a double write
    apply_stimulus("t6_pre", 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1; req_byte = 1'b0; req_double = 1'b1;
    req_addr = 32'h40; req_wdata = 32'hCAFEF00D; req_wdata_hi = 32'h0BADBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (LAT) @(posedge clk);
    #1;
    check_output("t6/stall_in_acc1", 32'(stall), 32'd1);
    check_output("t6/no_resp_yet", 32'(resp_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check_output("t6/ready_in_reset", 32'(req_ready), 32'd1);
    check_output("t6/stall_in_reset", 32'(stall), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("t6/resp_in_reset", 32'(resp_valid), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("t6/resp_after_reset", 32'(resp_valid), 32'd0);
    end
    check_output("t6/rdata_cleared", resp_rdata, 32'h0);
    mem_model[16] = 32'hCAFEF00D;
    exp_rdata = 32'h0;
    exp_hi    = 32'h0;
    exp_err   = 1'b0;
    apply_stimulus("t6_readback", 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 32'h0);
    check_output("t6_const_lo", resp_rdata, 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
